// File: rtl/gps_time_tx_pkg.sv
// Shared types and frame layout for the GPS time transmitter.
// frame_byte() maps a byte index to its on-wire value, including the checksum.
package gps_tx_pkg;

  localparam logic [7:0] SYNC0     = 8'hA5;
  localparam logic [7:0] SYNC1     = 8'h5A;
  localparam int         FRAME_LEN = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
  } snap_t;

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input snap_t s);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC0;
      4'd1:    b = SYNC1;
      4'd2:    b = s.year[15:8];
      4'd3:    b = s.year[7:0];
      4'd4:    b = s.month;
      4'd5:    b = s.day;
      4'd6:    b = s.hour;
      4'd7:    b = s.minute;
      4'd8:    b = s.second;
      // modulo-256 sum of the payload bytes
      4'd9:    b = s.year[15:8] + s.year[7:0] + s.month + s.day + s.hour + s.minute + s.second;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gps_time_tx_uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake.
// ready rises in the final stop-bit cycle so back-to-back bytes leave no idle gap.
module uart_tx_byte
  import gps_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       bit_r, bit_nxt_s;
  logic [7:0]       sh_r, sh_nxt_s;
  logic             txd_r, txd_nxt_s;
  logic             bit_end_s;

  assign bit_end_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
  assign ready     = (state_r == IDLE) || ((state_r == STOP) && bit_end_s);
  assign txd       = txd_r;

  // Line state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      bit_r   <= 3'd0;
      sh_r    <= 8'd0;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      sh_r    <= sh_nxt_s;
      txd_r   <= txd_nxt_s;
    end
  end

  // Bit timing and next line level
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    sh_nxt_s    = sh_r;
    txd_nxt_s   = txd_r;
    if (valid && ready) begin
      state_nxt_s = START;
      cnt_nxt_s   = {CNT_W{1'b0}};
      bit_nxt_s   = 3'd0;
      sh_nxt_s    = data;
      txd_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          txd_nxt_s = 1'b1;
        end
        START: begin
          if (bit_end_s) begin
            state_nxt_s = DATA;
            cnt_nxt_s   = {CNT_W{1'b0}};
            txd_nxt_s   = sh_r[0];
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (bit_r == 3'd7) begin
              state_nxt_s = STOP;
              txd_nxt_s   = 1'b1;
            end else begin
              bit_nxt_s = bit_r + 3'd1;
              sh_nxt_s  = {1'b0, sh_r[7:1]};
              txd_nxt_s = sh_r[1];
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            txd_nxt_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
          txd_nxt_s   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/gps_time_tx.sv
// PPS regeneration plus a 10-byte UART time frame sent on each qualifying pps_in rise.
// A rise landing in the frame's final stop-bit cycle chains straight into a new frame.
module gps_time_tx
  import gps_tx_pkg::*;
#(
  parameter int CLK_HZ        = 100000000,
  parameter int BAUD          = 115200,
  parameter int PPS_WIDTH_CYC = 10000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        pps_in,
  input  logic [31:0] year_in,
  input  logic [31:0] month_in,
  input  logic [31:0] day_in,
  input  logic [31:0] hour_in,
  input  logic [31:0] minute_in,
  input  logic [31:0] second_in,
  output logic        pps_out,
  output logic        txd,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PPS_W        = $clog2(PPS_WIDTH_CYC + 1);

  logic             pps_q_r, busy_r, overrun_r, pps_out_r;
  logic [3:0]       idx_r;
  snap_t            snap_r;
  logic [PPS_W-1:0] pps_cnt_r, pps_cnt_nxt_s;
  logic             pps_rise_s, frame_end_s, start_s, ovr_nxt_s;
  logic             u_valid_s, u_ready_s;
  logic [7:0]       u_data_s;
  logic             unused_s;

  assign unused_s = ^{year_in[31:16], month_in[31:8], day_in[31:8],
                      hour_in[31:8], minute_in[31:8], second_in[31:8]};

  assign pps_out    = pps_out_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign frame_done = frame_end_s;

  // Edge qualification, byte feed and pulse counter next value
  always_comb begin
    pps_rise_s    = pps_in & ~pps_q_r;
    frame_end_s   = busy_r & (idx_r == 4'd10) & u_ready_s;
    start_s       = pps_rise_s & en & (~busy_r | frame_end_s);
    ovr_nxt_s     = pps_rise_s & en & busy_r & ~frame_end_s;
    u_valid_s     = start_s | (busy_r & (idx_r < 4'd10));
    u_data_s      = 8'hFF;
    pps_cnt_nxt_s = pps_cnt_r;
    if (start_s) begin
      u_data_s = frame_byte(4'd0, snap_r);
    end else begin
      u_data_s = frame_byte(idx_r, snap_r);
    end
    if (pps_rise_s && en) begin
      pps_cnt_nxt_s = PPS_W'(PPS_WIDTH_CYC);
    end else if (pps_cnt_r != {PPS_W{1'b0}}) begin
      pps_cnt_nxt_s = pps_cnt_r - PPS_W'(1);
    end else begin
      pps_cnt_nxt_s = pps_cnt_r;
    end
  end

  // Snapshot, byte index, pulse and flag registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pps_q_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
      pps_out_r <= 1'b0;
      idx_r     <= 4'd0;
      snap_r    <= '0;
      pps_cnt_r <= {PPS_W{1'b0}};
    end else begin
      pps_q_r   <= pps_in;
      overrun_r <= ovr_nxt_s;
      pps_cnt_r <= pps_cnt_nxt_s;
      pps_out_r <= (pps_cnt_nxt_s != {PPS_W{1'b0}});
      if (start_s) begin
        snap_r <= {year_in[15:0], month_in[7:0], day_in[7:0],
                   hour_in[7:0], minute_in[7:0], second_in[7:0]};
        busy_r <= 1'b1;
        idx_r  <= 4'd1;
      end else if (frame_end_s) begin
        busy_r <= 1'b0;
        idx_r  <= 4'd0;
      end else if (u_valid_s && u_ready_s) begin
        idx_r <= idx_r + 4'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk    (clk),
    .resetn (resetn),
    .valid  (u_valid_s),
    .data   (u_data_s),
    .ready  (u_ready_s),
    .txd    (txd)
  );

endmodule

// File: doc/gps_time_tx.md
Name: gps_time_tx

Overview:
Transmit-side companion to the GPS time-of-day counter. On each second boundary (rising edge of pps_in from the local time base) it does two things:
- Drives a fixed-width PPS pulse on pps_out.
- Serializes a 10-byte binary time frame, snapshotted from the counter's year/month/day/hour/minute/second outputs, onto a UART 8N1 line.
Used to discipline downstream boards or to loop back into a GPS receiver path for test.

Parameters:
CLK_HZ, 100000000, clk frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 2)
PPS_WIDTH_CYC, 10000000, pps_out high time in clk cycles (must be >= 1)

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
en  in  1  enable starting new frames/pulses
pps_in  in  1  second tick, synchronous to clk; rising edge triggers
year_in  in  32  year count (bits [15:0] used)
month_in  in  32  month (bits [7:0] used)
day_in  in  32  day (bits [7:0] used)
hour_in  in  32  hour (bits [7:0] used)
minute_in  in  32  minute (bits [7:0] used)
second_in  in  32  second (bits [7:0] used)
pps_out  out  1  regenerated PPS pulse
txd  out  1  UART serial output, idle high
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last stop bit
overrun  out  1  one-cycle pulse: edge arrived while busy

Behaviour:
- Reset values (asserted on the clock edge where resetn=0): pps_out=0, txd=1, busy=0, frame_done=0, overrun=0, edge-detect flop=0, FSM=IDLE.
- Reset mid-frame: txd returns to 1 on the next cycle; the partial frame is abandoned.
- Edge detect: pps_rise = pps_in & ~pps_q, where pps_q is registered pps_in.
- Cycle N is the cycle in which pps_rise=1 and en=1. On the clock edge at the end of cycle N:
  - snapshot registers load the fields;
  - pps counter loads PPS_WIDTH_CYC;
  - FSM leaves IDLE.
- Latency: pps_out=1 and txd=0 (start bit) both from cycle N+1.
- pps_out: high for exactly PPS_WIDTH_CYC cycles.
  - A new qualifying rise while pps_out is high reloads the counter (pulse extends).
  - The pulse is independent of frame state.
- Frame bytes, in order:
  - 0xA5, 0x5A
  - year[15:8], year[7:0]
  - month[7:0], day[7:0], hour[7:0], minute[7:0], second[7:0]
  - CHK = 8-bit modulo-256 sum of bytes 2..8
- Byte format: start bit 0, data LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles. No idle gap between bytes. Frame length = 100*CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on qualifying rise.
  - START -> DATA after one bit time.
  - DATA -> STOP after 8 bits.
  - STOP -> START if byte index < 9, else IDLE.
- busy = (FSM != IDLE).
- frame_done pulses the cycle the final stop bit ends, i.e. the same edge on which FSM returns to IDLE.
- pps_rise while busy:
  - overrun pulses the following cycle;
  - snapshot is not updated and the frame is not restarted;
  - pps_out still reloads, if en=1.
- en=0: rises are ignored (no pulse, no frame, no overrun). An in-progress frame and pulse complete normally.
- Simultaneous frame_done and pps_rise in the same cycle: the rise is accepted and a new frame starts; no overrun.
- Field values above 8 bits (16 for year) are truncated; there is no range checking.

Decomposition:
- Package gps_tx_pkg:
  - SYNC0=8'hA5, SYNC1=8'h5A, FRAME_LEN=10
  - state enum {IDLE, START, DATA, STOP}
  - function frame_byte(idx, snapshot)
- Sub-module uart_tx_byte: bit-timing counter plus 8N1 shifter.
  - Interface: valid/ready byte handshake; ready=1 only when its internal line is idle or in the last stop-bit cycle.
  - Parameter CLKS_PER_BIT.
- The top level holds edge detect, snapshot, byte index, checksum, pps counter, and flags.

Test Plan:
All scenarios use CLK_HZ=1000, BAUD=100 (CLKS_PER_BIT=10), PPS_WIDTH_CYC=5.
1. Reset with pps_in=0 -> txd=1, pps_out=0, busy=0. Rise pps_in with en=1 -> pps_out high for exactly 5 cycles, txd low at N+1, busy high from N+1.
2. year=24, month=5, day=17, hour=13, minute=45, second=30 -> decoded bytes A5 5A 00 18 05 11 0D 2D 1E 86. frame_done pulses at cycle N+1000; txd stays 1 afterwards.
3. Change the fields mid-frame, then a second rise at cycle N+500 -> frame bytes unchanged; overrun pulses once at N+501; pps_out re-asserts for 5 cycles.
4. en=0 with pps_in rising -> no pps_out, no txd activity, no overrun. Deassert en mid-frame -> that frame still completes all 10 bytes.
5. resetn=0 at cycle N+230 for 1 cycle -> txd=1 and busy=0 next cycle. Next rise sends a complete, correct frame.
6. Rise timed exactly at the frame_done cycle -> new start bit begins with no idle gap; overrun=0.
